regfile_writeback: RTL



---
 rtl/regfile_writeback_pkg.sv | 12 +
 rtl/regfile_writeback_wb_fifo.sv | 49 ++++
 rtl/regfile_writeback.sv | 101 ++++++++++
 3 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared write-back request types used by the ALU, the load unit and regfile_writeback.
package regfile_writeback_pkg;

  localparam int addr_size = 5;
  localparam int cell_size = 32;

  typedef struct packed {
    logic [addr_size-1:0] rd;
    logic [cell_size-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Small synchronous FIFO of write-back requests; head is visible combinationally, no bypass.
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  wb_req_t       i_push_req,
  input  logic          i_pop,
  output wb_req_t       o_head,
  output logic [CW-1:0] o_count
);

  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage carries no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and load results onto the single regfile write port (ALU priority, starvation guard).
// Optional: REGFILE_WB_ZERO_REG_EN suppresses writes to register 0.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int  LOAD_DEPTH   = 2,
  parameter int  STARVE_LIMIT = 3,
  localparam int CW           = $clog2(LOAD_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [addr_size-1:0] alu_rd,
  input  logic [cell_size-1:0] alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [addr_size-1:0] ld_rd,
  input  logic [cell_size-1:0] ld_data,
  output logic                 wb_we,
  output logic [addr_size-1:0] wb_rd,
  output logic [cell_size-1:0] wb_data,
  output logic [CW-1:0]        ld_count
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] FULL_COUNT = CW'(LOAD_DEPTH);

  logic [SW-1:0]        r_starve;
  logic                 r_wb_we;
  logic [addr_size-1:0] r_wb_rd;
  logic [cell_size-1:0] r_wb_data;

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_force;
  logic          w_alu_grant;
  logic          w_ld_pop;
  logic          w_ld_push;
  logic          w_write;
  wb_req_t       w_head;
  wb_req_t       w_sel;

  wb_fifo #(.DEPTH(LOAD_DEPTH)) u_ld_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_ld_push),
    .i_push_req ({ld_rd, ld_data}),
    .i_pop      (w_ld_pop),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  // All arbitration terms depend only on registered state plus alu_valid.
  assign w_empty     = (w_count == '0);
  assign w_force     = (r_starve == STARVE_MAX) && !w_empty;
  assign w_alu_grant = alu_valid && !w_force;
  assign w_ld_pop    = !w_alu_grant && !w_empty;
  assign ld_ready    = (w_count != FULL_COUNT);
  assign w_ld_push   = ld_valid && ld_ready;
  assign w_sel       = w_alu_grant ? {alu_rd, alu_data} : w_head;

`ifdef REGFILE_WB_ZERO_REG_EN
  assign w_write = (w_alu_grant || w_ld_pop) && (w_sel.rd != '0);
`else
  assign w_write = w_alu_grant || w_ld_pop;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (w_ld_pop || w_empty) begin
      r_starve <= '0;
    end else if (w_alu_grant && (r_starve != STARVE_MAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Address and data hold their last written value while wb_we is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_we <= w_write;
      if (w_write) begin
        r_wb_rd   <= w_sel.rd;
        r_wb_data <= w_sel.data;
      end
    end
  end

  assign alu_ready = !w_force;
  assign wb_we     = r_wb_we;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign ld_count  = w_count;

endmodule
